spi_master: RTL and testbench



---
 rtl/spi_master.sv | 169 ++++++++++++++++
 tb/tb_spi_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-oriented CPOL=0 SPI master: one command per byte over valid/ready, MSB-first
// on mosi, miso sampled on each sck rise, with optional held slave select between bytes.
module spi_master #(
   parameter int NSLAVES = 4,
   parameter int HALF    = 4,
   parameter int SETUP   = 4,
   parameter int GAP     = 8,
   parameter int SELW    = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
   input  logic               Clk_i,
   input  logic               Rst_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [7:0]         cmd_data_i,
   input  logic [SELW-1:0]    cmd_sel_i,
   input  logic               cmd_hold_i,
   output logic [7:0]         rx_data_o,
   output logic               rx_valid_o,
   output logic               busy_o,
   output logic               sck_o,
   output logic               mosi_o,
   input  logic               miso_i,
   output logic [NSLAVES-1:0] ss_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [3:0]          bitcnt_q, bitcnt_d;
   logic [7:0]          tx_sr_q, tx_sr_d;
   logic [7:0]          rx_sr_q, rx_sr_d;
   logic                hold_q, hold_d;
   logic [NSLAVES-1:0]  ss_q, ss_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic [7:0]          rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                busy_q, busy_d;
   logic                do_rise;
   logic [NSLAVES-1:0]  sel_oh;

   // Out-of-range indices match no line, so such a frame runs with every select low.
   for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_sel
      assign sel_oh[gi] = (cmd_sel_i == SELW'(gi));
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      bitcnt_d   = bitcnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      hold_d     = hold_q;
      ss_d       = ss_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      do_rise    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (cmd_valid_i) begin
               state_d  = S_SETUP;
               tx_sr_d  = cmd_data_i;
               hold_d   = cmd_hold_i;
               bitcnt_d = '0;
               mosi_d   = cmd_data_i[7];
               ss_d     = sel_oh;
            end
         end
         S_SETUP: begin
            if (cnt_q == 16'(SETUP - 1)) do_rise = 1'b1;
         end
         S_HIGH: begin
            if (cnt_q == 16'(HALF - 1)) begin
               state_d = S_LOW;
               cnt_d   = '0;
               sck_d   = 1'b0;
               if (bitcnt_q < 4'd8) begin
                  mosi_d  = tx_sr_q[6];
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
               end
            end
         end
         S_LOW: begin
            if (cnt_q == 16'(HALF - 1)) begin
               if (bitcnt_q < 4'd8) begin
                  do_rise = 1'b1;
               end else begin
                  state_d    = S_GAP;
                  cnt_d      = '0;
                  rx_data_d  = rx_sr_q;
                  rx_valid_d = 1'b1;
                  if (!hold_q) ss_d = '0;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == 16'(GAP - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // miso is captured on the same edge that raises sck.
      if (do_rise) begin
         state_d  = S_HIGH;
         cnt_d    = '0;
         sck_d    = 1'b1;
         rx_sr_d  = {rx_sr_q[6:0], miso_i};
         bitcnt_d = bitcnt_q + 4'd1;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bitcnt_q   <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         hold_q     <= 1'b0;
         ss_q       <= '0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitcnt_q   <= bitcnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         hold_q     <= hold_d;
         ss_q       <= ss_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign rx_data_o   = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign busy_o      = busy_q;
   assign sck_o       = sck_q;
   assign mosi_o      = mosi_q;
   assign ss_o        = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: a 4-select and a 3-select instance share stimulus and
// are checked cycle by cycle against a schedule derived from the frame timing rules.
module tb_spi_master;

   localparam int HALF  = 4;
   localparam int SETUP = 4;
   localparam int GAP   = 8;
   localparam int T_RX  = 1 + SETUP + 16 * HALF;
   localparam int T_RDY = T_RX + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic [1:0] cmd_sel = 2'd0;
   logic       cmd_hold = 1'b0;
   logic       miso = 1'b0;

   logic       a_ready, a_rx_valid, a_busy, a_sck, a_mosi;
   logic [7:0] a_rx_data;
   logic [3:0] a_ss;
   logic       b_ready, b_rx_valid, b_busy, b_sck, b_mosi;
   logic [7:0] b_rx_data;
   logic [2:0] b_ss;

   int n_checks = 0;
   int n_pass   = 0;
   int n_frames = 0;
   logic [3:0] held4 = 4'b0000;
   logic [2:0] held3 = 3'b000;

   always #5 clk = ~clk;

   spi_master #(.NSLAVES(4), .HALF(HALF), .SETUP(SETUP), .GAP(GAP)) u_dut (
      .Clk_i(clk), .Rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(a_ready),
      .cmd_data_i(cmd_data), .cmd_sel_i(cmd_sel), .cmd_hold_i(cmd_hold),
      .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid), .busy_o(a_busy),
      .sck_o(a_sck), .mosi_o(a_mosi), .miso_i(miso), .ss_o(a_ss)
   );

   spi_master #(.NSLAVES(3), .HALF(HALF), .SETUP(SETUP), .GAP(GAP)) u_dut3 (
      .Clk_i(clk), .Rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(b_ready),
      .cmd_data_i(cmd_data), .cmd_sel_i(cmd_sel), .cmd_hold_i(cmd_hold),
      .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .busy_o(b_busy),
      .sck_o(b_sck), .mosi_o(b_mosi), .miso_i(miso), .ss_o(b_ss)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_sck"},      a_sck, 1'b0);
      check_val({tag, "_mosi"},     a_mosi, 1'b0);
      check_val({tag, "_ss"},       a_ss, 4'b0000);
      check_val({tag, "_rx_data"},  a_rx_data, 8'h00);
      check_val({tag, "_rx_valid"}, a_rx_valid, 1'b0);
      check_val({tag, "_busy"},     a_busy, 1'b0);
      check_val({tag, "_ready"},    a_ready, 1'b1);
      check_val({tag, "_ss3"},      b_ss, 3'b000);
      check_val({tag, "_ready3"},   b_ready, 1'b1);
   endtask

   // Called at the falling edge of an idle cycle; returns at the falling edge of the
   // first idle cycle after the frame.
   task automatic run_frame(input logic [7:0] tx, input logic [1:0] sel, input logic hold,
                            input logic [7:0] srx, input logic noise);
      logic [3:0] oh4;
      logic [2:0] oh3;
      logic       exp_sck;
      logic [3:0] exp_ss4;
      logic [2:0] exp_ss3;
      int         k;
      oh4 = 4'b0001 << sel;
      oh3 = (sel < 2'd3) ? 3'(3'b001 << sel) : 3'b000;
      check_val("ready_pre", a_ready, 1'b1);
      check_val("ss_pre", a_ss, held4);
      check_val("ss3_pre", b_ss, held3);
      cmd_valid = 1'b1;
      cmd_data  = tx;
      cmd_sel   = sel;
      cmd_hold  = hold;
      miso      = srx[7];
      for (int o = 1; o <= T_RDY; o++) begin
         @(negedge clk);
         k = (o - 1) / 8;
         if (k > 7) k = 7;
         exp_sck = (o >= 5) && (o < T_RX) && (((o - 5) % (2 * HALF)) < HALF);
         exp_ss4 = (o < T_RX || hold) ? oh4 : 4'b0000;
         exp_ss3 = (o < T_RX || hold) ? oh3 : 3'b000;
         check_val("sck", a_sck, exp_sck);
         check_val("sck3", b_sck, exp_sck);
         check_val("mosi", a_mosi, tx[7-k]);
         check_val("ss", a_ss, exp_ss4);
         check_val("ss3", b_ss, exp_ss3);
         check_val("busy", a_busy, o < T_RDY);
         check_val("ready", a_ready, o == T_RDY);
         check_val("rx_valid", a_rx_valid, o == T_RX);
         check_val("rx_valid3", b_rx_valid, o == T_RX);
         if (o == T_RX) begin
            check_val("rx_data", a_rx_data, srx);
            check_val("rx_data3", b_rx_data, srx);
         end
         miso = srx[7-k];
         if (noise && o < T_RDY - 1) begin
            cmd_valid = 1'b1;
            cmd_data  = 8'($urandom);
            cmd_sel   = 2'($urandom);
            cmd_hold  = 1'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      held4 = hold ? oh4 : 4'b0000;
      held3 = hold ? oh3 : 3'b000;
      n_frames++;
      $display("frame %0d: tx=%02h sel=%0d hold=%0b slave=%02h rx=%02h rx3=%02h",
               n_frames, tx, sel, hold, srx, a_rx_data, b_rx_data);
   endtask

   task automatic reset_mid_frame();
      int pulses;
      int ss_on;
      check_val("rst_ready_pre", a_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_data  = 8'hC3;
      cmd_sel   = 2'd1;
      cmd_hold  = 1'b1;
      miso      = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      check_val("rst_in_high_sck", a_sck, 1'b1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset("rst_mid");
      pulses = 0;
      ss_on  = 0;
      for (int i = 0; i < T_RDY + 4; i++) begin
         @(negedge clk);
         if (a_rx_valid || b_rx_valid) pulses++;
         if (a_ss != 4'b0000 || a_sck) ss_on++;
      end
      check_val("rst_no_rx_valid", pulses, 0);
      check_val("rst_bus_idle", ss_on, 0);
      held4 = 4'b0000;
      held3 = 3'b000;
      $display("reset mid-frame: rx_valid pulses=%0d active bus cycles=%0d", pulses, ss_on);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      run_frame(8'hA5, 2'd1, 1'b0, 8'h3C, 1'b0);
      run_frame(8'h01, 2'd2, 1'b1, 8'h81, 1'b0);
      run_frame(8'hFF, 2'd2, 1'b0, 8'h7E, 1'b1);
      run_frame(8'h11, 2'd0, 1'b1, 8'h00, 1'b0);
      run_frame(8'h22, 2'd3, 1'b0, 8'hFF, 1'b0);
      run_frame(8'h5A, 2'd1, 1'b0, 8'h96, 1'b1);
      for (int n = 0; n < 12; n++) begin
         run_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   8'($urandom), 1'($urandom));
      end
      run_frame(8'h3C, 2'd1, 1'b1, 8'h55, 1'b0);
      reset_mid_frame();
      run_frame(8'h96, 2'd0, 1'b0, 8'hA5, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
